// File: rtl/serial_adder_ctrl.sv
// Bit-serial unsigned adder: one full-adder cell, one bit per clock, LSB first.
// Operands are captured on an accepted start, the carry is held in a flop
// between bits, and the finished sum/cout are registered with a done pulse.

// Gate-level full-adder cell shared by every bit position.
module fa_struct (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  assign ab_x = a ^ b;
  assign ab_a = a & b;
  assign cx_a = ab_x & ci;
  assign s    = ab_x ^ ci;
  assign co   = ab_a | cx_a;

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] s_sr_shift;

  // The single adder cell always looks at the current LSBs and the held carry.
  fa_struct u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign s_sr_shift = (s_sr_q >> 1) | {fa_s, {(WIDTH-1){1'b0}}};

  // Next-state and datapath update for the serial add sequence.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = s_sr_shift;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Last bit: publish the completed word and the final carry together.
          sum_d   = s_sr_shift;
          cout_d  = fa_co;
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the state being entered.
    busy_d = (state_d == ADD);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered outputs; reset aborts any operation at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=16
// against a plain-arithmetic model of a+b+cin.
module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        cin8 = 1'b0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        cin16 = 1'b0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .cin   (cin16),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (cout16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] g_sum(input int w);
    return (w == 8) ? 32'(sum8) : 32'(sum16);
  endfunction
  function automatic logic [31:0] g_cout(input int w);
    return (w == 8) ? 32'(cout8) : 32'(cout16);
  endfunction
  function automatic logic [31:0] g_busy(input int w);
    return (w == 8) ? 32'(busy8) : 32'(busy16);
  endfunction
  function automatic logic [31:0] g_done(input int w);
    return (w == 8) ? 32'(done8) : 32'(done16);
  endfunction

  task automatic drive(input int w, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input logic st);
    if (w == 8) begin
      a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv; start8 = st;
    end else begin
      a16 = av; b16 = bv; cin16 = cv; start16 = st;
    end
  endtask

  // One complete operation with cycle-exact checks; inject>0 pulses a stray
  // start (a=b=0x11) after that many ADD cycles.
  task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input int inject);
    logic [31:0] total, mask, exp_sum, exp_cout, prev_sum, prev_cout;
    mask      = (32'd1 << w) - 32'd1;
    total     = (32'(av) & mask) + (32'(bv) & mask) + 32'(cv);
    exp_sum   = total & mask;
    exp_cout  = (total >> w) & 32'd1;
    prev_sum  = g_sum(w);
    prev_cout = g_cout(w);

    @(negedge clk);
    drive(w, av, bv, cv, 1'b1);
    @(posedge clk); #1;
    drive(w, ~av, ~bv, ~cv, 1'b0);
    check("accept_busy", g_busy(w), 32'd1);
    check("accept_done", g_done(w), 32'd0);
    for (int i = 1; i < w; i++) begin
      @(posedge clk); #1;
      if (inject > 0 && i == inject + 1) drive(w, ~av, ~bv, ~cv, 1'b0);
      check("add_busy", g_busy(w), 32'd1);
      check("add_done", g_done(w), 32'd0);
      check("add_sum_hold", g_sum(w), prev_sum);
      check("add_cout_hold", g_cout(w), prev_cout);
      if (inject > 0 && i == inject) drive(w, 16'h0011, 16'h0011, 1'b0, 1'b1);
    end
    @(posedge clk); #1;
    check("done_pulse", g_done(w), 32'd1);
    check("done_busy", g_busy(w), 32'd0);
    check("result_sum", g_sum(w), exp_sum);
    check("result_cout", g_cout(w), exp_cout);
    @(posedge clk); #1;
    check("post_done", g_done(w), 32'd0);
    check("post_busy", g_busy(w), 32'd0);
    check("post_sum_hold", g_sum(w), exp_sum);
  endtask

  initial begin
    int pulses[$];
    logic [31:0] held;
    logic saw_done;

    // Reset values of both instances.
    #12;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_sum8", 32'(sum8), 32'd0);
    check("rst_cout8", 32'(cout8), 32'd0);
    check("rst_busy16", 32'(busy16), 32'd0);
    check("rst_sum16", 32'(sum16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operands, including full carry propagation.
    run_op(8, 16'h005A, 16'h003C, 1'b0, 0);
    run_op(8, 16'h00FF, 16'h0001, 1'b0, 0);
    run_op(8, 16'h00FF, 16'h00FF, 1'b1, 0);
    run_op(8, 16'h005A, 16'h003C, 1'b0, 0);

    // Stray start during ADD is ignored.
    run_op(8, 16'h0033, 16'h0044, 1'b1, 3);

    // Reset in the middle of an operation.
    @(negedge clk);
    drive(8, 16'h0012, 16'h0034, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(8, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy_before_rst", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_sum", 32'(sum8), 32'd0);
    check("abort_cout", 32'(cout8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) saw_done = 1'b1;
    end
    check("no_done_after_abort", 32'(saw_done), 32'd0);
    run_op(8, 16'h00C8, 16'h0064, 1'b1, 0);

    // start held high: back-to-back operations every WIDTH+2 clocks.
    held = 32'(sum8);
    @(negedge clk);
    drive(8, 16'h00A5, 16'h000F, 1'b1, 1'b1);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        pulses.push_back(k);
        check("held_sum", 32'(sum8), 32'h000000B5);
        check("held_cout", 32'(cout8), 32'd0);
        held = 32'h000000B5;
      end else begin
        check("held_sum_hold", 32'(sum8), held);
      end
      if (k == 29) drive(8, 16'h00A5, 16'h000F, 1'b1, 1'b0);
    end
    check("held_pulse_count", 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3) begin
      check("held_first_latency", 32'(pulses[0]), 32'd8);
      check("held_spacing_1", 32'(pulses[1] - pulses[0]), 32'd10);
      check("held_spacing_2", 32'(pulses[2] - pulses[1]), 32'd10);
    end
    repeat (2) @(posedge clk);
    #1;
    check("held_stop_busy", 32'(busy8), 32'd0);

    // Random operands at both widths.
    for (int n = 0; n < 1000; n++)
      run_op(8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 0);
    run_op(16, 16'hFFFF, 16'h0001, 1'b0, 0);
    for (int n = 0; n < 1000; n++)
      run_op(16, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
             1'($urandom_range(0, 1)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
